// File: rtl/sent_pkg.sv
// Shared types and constants for the SENT transmit pulse generator.
package sent_pkg;

    typedef enum logic [1:0] {
        KIND_SYNC,
        KIND_PAUSE,
        KIND_NIBBLE
    } kind_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH
    } pg_state_t;

    localparam logic [9:0] SYNC_TICKS        = 10'd56;
    localparam logic [9:0] NIBBLE_BASE_TICKS = 10'd12;
    localparam logic [9:0] MIN_PAUSE_TICKS   = 10'd12;
    localparam logic [9:0] MAX_PAUSE_TICKS   = 10'd768;

    // Request priority: sync > pause > nibble
    function automatic kind_t pick_kind(input logic sync_req, input logic pause_req);
        if (sync_req)
            return KIND_SYNC;
        else if (pause_req)
            return KIND_PAUSE;
        else
            return KIND_NIBBLE;
    endfunction

endpackage

// File: rtl/sent_tx_pulse_gen_prescaler.sv
// sent_tick_prescaler: divide-by-TICK_DIV counter with synchronous restart.
// tick is high on the last clk of every tick; tick_next predicts tick for
// the following clk so the parent can register end-of-pulse strobes.
module sent_tick_prescaler #(
    parameter int unsigned TICK_DIV = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick,
    output logic tick_next
);

    localparam int unsigned PW = $clog2(TICK_DIV) + 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRE  = (TICK_DIV > 1) ? PW'(TICK_DIV - 2) : '0;
    localparam logic DIV_ONE = (TICK_DIV == 1);

    logic [PW-1:0] cnt;

    assign tick = (cnt == LAST);

    // After a restart cnt is 0, so the next clk ticks only when dividing by one
    assign tick_next = DIV_ONE || (!restart && (cnt == PRE));

    // Free-running modulo-TICK_DIV count, forced to 0 on restart
    always_ff @(posedge clk) begin
        if (reset || restart)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/sent_tx_pulse_gen.sv
// sent_tx_pulse_gen: tick-timed SENT line pulse generator.
// Optional feature macro SENT_TX_PG_FIXED_FRAME_EN: pause length is derived
// from a frame tick accumulator so every frame is FRAME_TICKS long.
module sent_tx_pulse_gen
    import sent_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 3,
    parameter int unsigned LOW_TICKS   = 5,
    parameter int unsigned PAUSE_TICKS = 77,
    parameter int unsigned FRAME_TICKS = 282
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sync,
    input  logic       pause,
    input  logic       pulse,
    input  logic [3:0] data_nibble,
    output logic       pulse_done,
    output logic       data_pulse,
    output logic       busy,
    output logic       abort
);

    if ((LOW_TICKS * TICK_DIV < 4) || (PAUSE_TICKS < 12) || (PAUSE_TICKS > 768) ||
        (FRAME_TICKS > 4095)) begin : g_bad_params
        $error("sent_tx_pulse_gen: parameter out of range");
    end

    pg_state_t  state;
    logic [9:0] tick_cnt;
    logic [9:0] total_ticks;
    logic       tick;
    logic       tick_next;
    logic       restart;
    logic       any_req;
    logic       low_end;
    logic       hi_end;
    logic       stay_high;
    kind_t      req_kind;
    logic [9:0] req_total;
    logic [9:0] pause_ticks;
    logic [9:0] next_total;
    logic [9:0] tick_cnt_nxt;

    assign any_req = sync | pause | pulse;
    assign low_end = (state == ST_LOW) && tick && (tick_cnt == 10'(LOW_TICKS - 1));
    assign hi_end  = (state == ST_HIGH) && tick && (tick_cnt == total_ticks - 10'd1);
    assign restart = (state == ST_IDLE) || hi_end;

    sent_tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart),
        .tick     (tick),
        .tick_next(tick_next)
    );

`ifdef SENT_TX_PG_FIXED_FRAME_EN
    logic [11:0] frame_acc;
    logic [13:0] frame_rem;

    assign frame_rem = 14'(FRAME_TICKS) - {2'b00, frame_acc};

    // Remaining frame ticks, clamped to the legal pause range
    always_comb begin
        if (frame_rem[13] || (frame_rem < {4'b0, MIN_PAUSE_TICKS}))
            pause_ticks = MIN_PAUSE_TICKS;
        else if (frame_rem > {4'b0, MAX_PAUSE_TICKS})
            pause_ticks = MAX_PAUSE_TICKS;
        else
            pause_ticks = frame_rem[9:0];
    end

    // Frame accumulator: restarts with each sync, adds every latched pulse
    always_ff @(posedge clk) begin
        if (reset)
            frame_acc <= '0;
        else if (low_end && any_req) begin
            if (req_kind == KIND_SYNC)
                frame_acc <= {2'b00, SYNC_TICKS};
            else
                frame_acc <= frame_acc + {2'b00, req_total};
        end
    end
`else
    assign pause_ticks = 10'(PAUSE_TICKS);
`endif

    // Pulse length for the request currently presented
    always_comb begin
        req_kind = pick_kind(sync, pause);
        case (req_kind)
            KIND_SYNC:  req_total = SYNC_TICKS;
            KIND_PAUSE: req_total = pause_ticks;
            default:    req_total = NIBBLE_BASE_TICKS + {6'b0, data_nibble};
        endcase
    end

    // pulse_done is registered, so predict whether the next clk is the last
    // one of the pulse from the prescaler's look-ahead strobe.
    always_comb begin
        next_total   = low_end ? req_total : total_ticks;
        tick_cnt_nxt = tick_cnt + {9'b0, tick};
        stay_high    = ((state == ST_HIGH) && !hi_end) || (low_end && any_req);
    end

    // Pulse FSM with registered line, busy and strobe outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            tick_cnt    <= '0;
            total_ticks <= '0;
            data_pulse  <= 1'b1;
            busy        <= 1'b0;
            pulse_done  <= 1'b0;
            abort       <= 1'b0;
        end else begin
            pulse_done <= stay_high && tick_next && (tick_cnt_nxt == next_total - 10'd1);
            abort      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tick_cnt <= '0;
                    if (any_req) begin
                        state      <= ST_LOW;
                        data_pulse <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                ST_LOW: begin
                    tick_cnt <= tick_cnt_nxt;
                    if (low_end) begin
                        data_pulse <= 1'b1;
                        if (any_req) begin
                            state       <= ST_HIGH;
                            total_ticks <= req_total;
                        end else begin
                            state    <= ST_IDLE;
                            busy     <= 1'b0;
                            abort    <= 1'b1;
                            tick_cnt <= '0;
                        end
                    end
                end
                ST_HIGH: begin
                    if (hi_end) begin
                        tick_cnt <= '0;
                        if (any_req) begin
                            state      <= ST_LOW;
                            data_pulse <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        tick_cnt <= tick_cnt_nxt;
                    end
                end
                default: begin
                    state      <= ST_IDLE;
                    tick_cnt   <= '0;
                    data_pulse <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sent_tx_pulse_gen.sv
// Self-checking bench for sent_tx_pulse_gen: directed table, corner-case
// sequences and randomized requests against a clk-position reference model.
module tb_sent_tx_pulse_gen;

    localparam int TB_DIV   = 2;
    localparam int TB_LOW   = 5;
    localparam int TB_PAUSE = 77;
    localparam int TB_FRAME = 282;
    localparam int LOW_CLKS = TB_LOW * TB_DIV;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sync = 1'b0;
    logic       pause = 1'b0;
    logic       pulse = 1'b0;
    logic [3:0] data_nibble = 4'd0;
    logic       pulse_done;
    logic       data_pulse;
    logic       busy;
    logic       abort;

    int errors = 0;
    int checks = 0;

    sent_tx_pulse_gen #(
        .TICK_DIV   (TB_DIV),
        .LOW_TICKS  (TB_LOW),
        .PAUSE_TICKS(TB_PAUSE),
        .FRAME_TICKS(TB_FRAME)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .sync       (sync),
        .pause      (pause),
        .pulse      (pulse),
        .data_nibble(data_nibble),
        .pulse_done (pulse_done),
        .data_pulse (data_pulse),
        .busy       (busy),
        .abort      (abort)
    );

    always #5 clk = ~clk;

    // Reference model: position of the current clk inside the pulse
    bit m_in;
    int m_p;
    bit m_lat;
    int m_T;
    bit m_abort;
    int m_acc;

    function automatic int model_pause_ticks();
`ifdef SENT_TX_PG_FIXED_FRAME_EN
        int d;
        d = TB_FRAME - m_acc;
        if (d < 12) d = 12;
        if (d > 768) d = 768;
        return d;
`else
        return TB_PAUSE;
`endif
    endfunction

    task automatic model_step();
        int tot;
        bit req;
        req = sync | pause | pulse;
        m_abort = 1'b0;
        if (reset) begin
            m_in = 0; m_p = 0; m_lat = 0; m_T = 0; m_acc = 0;
        end else if (!m_in) begin
            if (req) begin
                m_in = 1; m_p = 0; m_lat = 0;
            end
        end else if (!m_lat && m_p == LOW_CLKS - 1) begin
            if (req) begin
                if (sync) tot = 56;
                else if (pause) tot = model_pause_ticks();
                else tot = 12 + int'(data_nibble);
                if (sync) m_acc = 56;
                else m_acc = (m_acc + tot) % 4096;
                m_T = tot * TB_DIV;
                m_lat = 1;
                m_p = m_p + 1;
            end else begin
                m_in = 0;
                m_abort = 1'b1;
            end
        end else if (m_lat && m_p == m_T - 1) begin
            if (req) begin
                m_p = 0; m_lat = 0;
            end else begin
                m_in = 0;
            end
        end else begin
            m_p = m_p + 1;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clk: model follows the edge, outputs checked on the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("model data_pulse", int'(data_pulse), int'(!(m_in && m_p < LOW_CLKS)));
        chk("model busy", int'(busy), int'(m_in));
        chk("model pulse_done", int'(pulse_done), int'(m_in && m_lat && m_p == m_T - 1));
        chk("model abort", int'(abort), int'(m_abort));
    endtask

    task automatic wait_done(input int limit, output int lowc, output int busyc, output bit ok);
        lowc = 0; busyc = 0; ok = 0;
        for (int i = 0; i < limit; i++) begin
            cycle();
            if (busy) busyc++;
            if (!data_pulse) lowc++;
            if (pulse_done) begin
                ok = 1;
                return;
            end
        end
        chk("wait_done timeout", 0, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; sync = 0; pause = 0; pulse = 0;
        cycle(); cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        bit       s;
        bit       pa;
        bit       pu;
        bit [3:0] nib;
        int       exp_low;
        int       exp_busy;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int lowc, busyc, cnt_done;
        bit ok, saw_abort;
        int exp_pause_iso, exp_pause_crc, exp_pause_frame;

`ifdef SENT_TX_PG_FIXED_FRAME_EN
        exp_pause_iso   = 282 * TB_DIV;
        exp_pause_crc   = (282 - 15) * TB_DIV;
        exp_pause_frame = 130 * TB_DIV;
`else
        exp_pause_iso   = 154;
        exp_pause_crc   = 154;
        exp_pause_frame = 154;
`endif

        tbl[0] = '{s: 0, pa: 0, pu: 1, nib: 4'h0, exp_low: 10, exp_busy: 24};
        tbl[1] = '{s: 0, pa: 0, pu: 1, nib: 4'hF, exp_low: 10, exp_busy: 54};
        tbl[2] = '{s: 0, pa: 0, pu: 1, nib: 4'h5, exp_low: 10, exp_busy: 34};
        tbl[3] = '{s: 1, pa: 0, pu: 0, nib: 4'h3, exp_low: 10, exp_busy: 112};
        tbl[4] = '{s: 0, pa: 1, pu: 0, nib: 4'h0, exp_low: 10, exp_busy: exp_pause_iso};
        tbl[5] = '{s: 1, pa: 1, pu: 1, nib: 4'h9, exp_low: 10, exp_busy: 112};

        m_in = 0; m_p = 0; m_lat = 0; m_T = 0; m_abort = 0; m_acc = 0;

        // Reset values
        @(negedge clk);
        cycle(); cycle();
        chk("reset data_pulse", int'(data_pulse), 1);
        chk("reset busy", int'(busy), 0);
        chk("reset pulse_done", int'(pulse_done), 0);
        chk("reset abort", int'(abort), 0);

        // Single isolated pulses from the table
        for (int r = 0; r < 6; r++) begin
            do_reset();
            sync = tbl[r].s; pause = tbl[r].pa; pulse = tbl[r].pu; data_nibble = tbl[r].nib;
            wait_done(2000, lowc, busyc, ok);
            chk($sformatf("row%0d done", r), int'(ok), 1);
            chk($sformatf("row%0d low clks", r), lowc, tbl[r].exp_low);
            chk($sformatf("row%0d period", r), busyc, tbl[r].exp_busy);
            sync = 0; pause = 0; pulse = 0;
            cycle();
            chk($sformatf("row%0d idle line", r), int'(data_pulse), 1);
            chk($sformatf("row%0d idle busy", r), int'(busy), 0);
        end

        // Sync held through pulse_done, nibble request arrives 2 clks later
        do_reset();
        sync = 1;
        wait_done(500, lowc, busyc, ok);
        chk("b2b sync period", busyc, 112);
        cycle();
        chk("b2b no gap line", int'(data_pulse), 0);
        chk("b2b no gap busy", int'(busy), 1);
        sync = 0;
        cycle();
        pulse = 1; data_nibble = 4'h5;
        wait_done(500, lowc, busyc, ok);
        chk("b2b nibble period", busyc + 2, 34);
        pulse = 0;
        cycle();

        // CRC pulse, pause asserted late into the next LOW phase
        do_reset();
        pulse = 1; data_nibble = 4'h3;
        wait_done(500, lowc, busyc, ok);
        chk("crc period", busyc, 30);
        cycle();
        chk("crc->pause no gap", int'(data_pulse), 0);
        pulse = 0;
        cycle();
        pause = 1;
        wait_done(2000, lowc, busyc, ok);
        chk("pause period", busyc + 2, exp_pause_crc);
        pause = 0;
        cycle();

        // Full frame: sync, 8 zero nibbles, then pause
        do_reset();
        sync = 1;
        wait_done(500, lowc, busyc, ok);
        chk("frame sync period", busyc, 112);
        sync = 0; pulse = 1; data_nibble = 4'h0;
        for (int n = 0; n < 8; n++) begin
            wait_done(500, lowc, busyc, ok);
            chk($sformatf("frame nibble%0d period", n), busyc, 24);
        end
        pulse = 0; pause = 1;
        wait_done(2000, lowc, busyc, ok);
        chk("frame pause period", busyc, exp_pause_frame);
        pause = 0;
        cycle();

        // Request withdrawn during LOW -> abort
        do_reset();
        pulse = 1; data_nibble = 4'h7;
        cycle(); cycle(); cycle();
        pulse = 0;
        saw_abort = 0; cnt_done = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (abort) saw_abort = 1;
            if (pulse_done) cnt_done++;
        end
        chk("abort strobe", int'(saw_abort), 1);
        chk("abort no done", cnt_done, 0);
        chk("abort line high", int'(data_pulse), 1);
        chk("abort busy low", int'(busy), 0);

        // Reset during HIGH
        do_reset();
        pulse = 1; data_nibble = 4'hF;
        for (int i = 0; i < 15; i++) cycle();
        chk("midhigh line", int'(data_pulse), 1);
        chk("midhigh busy", int'(busy), 1);
        pulse = 0; reset = 1;
        cycle();
        chk("rst line", int'(data_pulse), 1);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(pulse_done), 0);
        reset = 0;
        cnt_done = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (pulse_done) cnt_done++;
        end
        chk("rst no late done", cnt_done, 0);

        // Randomized requests against the model
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(5, 0) == 0) begin
                sync        = ($urandom_range(7, 0) == 0);
                pause       = ($urandom_range(4, 0) == 0);
                pulse       = ($urandom_range(1, 0) == 1);
                data_nibble = 4'($urandom_range(15, 0));
            end
            reset = ($urandom_range(599, 0) == 0);
            cycle();
        end
        reset = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
